// File: rtl/riscboy_ppu_lcdrx.sv
// riscboy_ppu_lcdrx: oversampling serial LCD receiver that deserialises MSB-first words onto a valid/ready stream; define RISCBOY_PPU_LCDRX_GLITCH_FILTER_EN for sck/cs glitch rejection
module riscboy_ppu_lcdrx #(
  parameter int W_DATA  = 16,
  parameter int W_SHAMT = $clog2(W_DATA + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lcd_cs,
  input  logic               lcd_dc,
  input  logic               lcd_sck,
  input  logic               lcd_mosi,
  input  logic [W_SHAMT-1:0] shiftcnt,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [W_DATA-1:0]  out_data,
  output logic               out_dc,
  output logic               busy,
  output logic               err_ovf,
  output logic               err_part,
  input  logic               err_clr
);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;
  localparam logic [W_SHAMT-1:0] L_MAX = W_SHAMT'(W_DATA);
`ifdef RISCBOY_PPU_LCDRX_GLITCH_FILTER_EN
  localparam int N_SYNC = 3;
`else
  localparam int N_SYNC = 2;
`endif
  logic [N_SYNC-1:0]  cs_q, sck_q;
  logic [1:0]         dc_q, mosi_q;
  logic               cs_s, sck_s, dc_s, mosi_s, sck_prev;
  logic [0:0]         state;
  logic [W_SHAMT-1:0] bitcnt, bit_inc, len;
  logic [W_DATA-1:0]  sr, sr_next;
  logic               rise, shift_en, done, partial, cs_end, load;
  // Synchronise the asynchronous link pins; cs idles high so its chain resets to 1
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cs_q   <= '1;
      sck_q  <= '0;
      dc_q   <= '0;
      mosi_q <= '0;
    end else begin
      cs_q   <= {cs_q[N_SYNC-2:0], lcd_cs};
      sck_q  <= {sck_q[N_SYNC-2:0], lcd_sck};
      dc_q   <= {dc_q[0], lcd_dc};
      mosi_q <= {mosi_q[0], lcd_mosi};
    end
`ifdef RISCBOY_PPU_LCDRX_GLITCH_FILTER_EN
  logic cs_h;
  assign cs_s  = (cs_q[1] == cs_q[2]) ? cs_q[2] : cs_h;
  assign sck_s = (sck_q[1] == sck_q[2]) ? sck_q[2] : sck_prev;
  // Hold the last accepted cs level until two equal samples agree on a new one
  always_ff @(posedge clk or posedge rst)
    if (rst) cs_h <= 1'b1;
    else     cs_h <= cs_s;
`else
  assign cs_s  = cs_q[1];
  assign sck_s = sck_q[1];
`endif
  assign dc_s     = dc_q[1];
  assign mosi_s   = mosi_q[1];
  assign busy     = ~cs_s;
  assign len      = (shiftcnt > L_MAX) ? L_MAX : shiftcnt;
  assign bit_inc  = bitcnt + 1'b1;
  assign rise     = sck_s & ~sck_prev;
  assign shift_en = (state == S_SHIFT) && rise && (len != '0);
  assign done     = shift_en && (bit_inc == len);
  assign sr_next  = W_DATA'({sr, mosi_s});
  assign partial  = shift_en ? ~done : (bitcnt != '0);
  assign cs_end   = (state == S_SHIFT) && cs_s;
  assign load     = done && (~out_vld || out_rdy);
  // Edge detector history for the synchronised serial clock
  always_ff @(posedge clk or posedge rst)
    if (rst) sck_prev <= 1'b0;
    else     sck_prev <= sck_s;
  // Framing FSM and shift register; a completed word restarts the count inside the same cs window
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= S_IDLE;
      bitcnt <= '0;
      sr     <= '0;
    end else if (state == S_IDLE) begin
      bitcnt <= '0;
      sr     <= '0;
      if (!cs_s) state <= S_SHIFT;
    end else if (cs_s || done) begin
      state  <= cs_s ? S_IDLE : S_SHIFT;
      bitcnt <= '0;
      sr     <= '0;
    end else if (shift_en) begin
      bitcnt <= bit_inc;
      sr     <= sr_next;
    end
  // Single-entry output register; a word arriving while it is held and not drained is dropped
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_dc   <= 1'b0;
    end else if (load) begin
      out_vld  <= 1'b1;
      out_data <= sr_next;
      out_dc   <= dc_s;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  // Sticky error flags; a new event wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      err_ovf  <= 1'b0;
      err_part <= 1'b0;
    end else begin
      err_ovf  <= (err_ovf & ~err_clr) | (done & out_vld & ~out_rdy);
      err_part <= (err_part & ~err_clr) | (cs_end & partial);
    end
endmodule

// File: tb/tb_riscboy_ppu_lcdrx.sv
// tb_riscboy_ppu_lcdrx: randomized self-checking bench for the serial LCD receiver
module tb_riscboy_ppu_lcdrx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lcd_cs = 1'b1, lcd_dc = 1'b0, lcd_sck = 1'b0, lcd_mosi = 1'b0;
  logic [4:0]  shiftcnt = 5'd16;
  logic        out_vld, out_rdy = 1'b1, out_dc, busy, err_ovf, err_part, err_clr = 1'b0;
  logic [15:0] out_data;
  int          checks = 0, failures = 0;
  logic [16:0] got[$];
  logic [16:0] exp_q[$];

  riscboy_ppu_lcdrx dut (
    .clk(clk), .rst(rst), .lcd_cs(lcd_cs), .lcd_dc(lcd_dc), .lcd_sck(lcd_sck),
    .lcd_mosi(lcd_mosi), .shiftcnt(shiftcnt), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .out_dc(out_dc), .busy(busy), .err_ovf(err_ovf),
    .err_part(err_part), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && out_vld && out_rdy) got.push_back({out_dc, out_data});

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    lcd_cs = 1'b0;
    tick(5);
  endtask

  task automatic cs_high();
    tick(2);
    lcd_cs = 1'b1;
    tick(8);
  endtask

  task automatic send_bits(input logic [15:0] val, input int n, input logic dc);
    for (int i = n - 1; i >= 0; i--) begin
      lcd_mosi = val[i];
      lcd_dc   = dc;
      lcd_sck  = 1'b0;
      tick(4);
      lcd_sck  = 1'b1;
      tick(4);
    end
    lcd_sck = 1'b0;
    tick(4);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
  endtask

  function automatic logic [15:0] mask_of(input int l);
    int m;
    m = (l >= 16) ? 32'hFFFF : ((32'h1 << l) - 1);
    return m[15:0];
  endfunction

  task automatic wait_beats(input int n, input string name);
    int t;
    t = 0;
    while (got.size() < n && t < 100) begin
      tick(1);
      t++;
    end
    checks++;
    if (got.size() !== n) begin
      failures++;
      $display("FAIL %s beat_count got=%0d exp=%0d", name, got.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", out_vld); end
    checks++; if (out_data !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0000", out_data); end
    checks++; if ({out_dc, busy, err_ovf, err_part} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {out_dc, busy, err_ovf, err_part}); end
    rst = 1'b0;
    tick(3);
    lcd_cs = 1'b0;
    tick(5);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_low got=%b exp=1", busy); end
    lcd_cs = 1'b1;
    tick(5);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_high got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    got.delete();
    shiftcnt = 5'd16;
    cs_low();
    send_bits(16'hA5C3, 16, 1'b1);
    cs_high();
    wait_beats(1, "single");
    if (got.size() > 0) begin
      checks++; if (got[0] !== {1'b1, 16'hA5C3}) begin failures++; $display("FAIL single_word got=%h exp=%h", got[0], {1'b1, 16'hA5C3}); end
    end
    checks++; if ({err_ovf, err_part} !== 2'b00) begin failures++; $display("FAIL single_err got=%b exp=00", {err_ovf, err_part}); end
  endtask

  task automatic test_back_to_back();
    got.delete();
    shiftcnt = 5'd8;
    cs_low();
    send_bits(16'h2A, 8, 1'b0);
    send_bits(16'h55, 8, 1'b1);
    cs_high();
    wait_beats(2, "b2b");
    if (got.size() > 1) begin
      checks++; if (got[0] !== {1'b0, 16'h002A}) begin failures++; $display("FAIL b2b_w0 got=%h exp=%h", got[0], {1'b0, 16'h002A}); end
      checks++; if (got[1] !== {1'b1, 16'h0055}) begin failures++; $display("FAIL b2b_w1 got=%h exp=%h", got[1], {1'b1, 16'h0055}); end
    end
  endtask

  task automatic test_overflow();
    got.delete();
    shiftcnt = 5'd16;
    out_rdy = 1'b0;
    cs_low();
    send_bits(16'h1111, 16, 1'b1);
    send_bits(16'h2222, 16, 1'b0);
    cs_high();
    checks++; if ({out_vld, out_dc, out_data} !== {2'b11, 16'h1111}) begin failures++; $display("FAIL ovf_held got=%h exp=%h", {out_vld, out_dc, out_data}, {2'b11, 16'h1111}); end
    checks++; if (err_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", err_ovf); end
    pulse_clr();
    checks++; if (err_ovf !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", err_ovf); end
    checks++; if ({out_vld, out_data} !== {1'b1, 16'h1111}) begin failures++; $display("FAIL ovf_after_clr got=%h exp=%h", {out_vld, out_data}, {1'b1, 16'h1111}); end
    out_rdy = 1'b1;
    tick(3);
    wait_beats(1, "ovf_drain");
    if (got.size() > 0) begin
      checks++; if (got[0] !== {1'b1, 16'h1111}) begin failures++; $display("FAIL ovf_drain got=%h exp=%h", got[0], {1'b1, 16'h1111}); end
    end
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL ovf_vld_clear got=%b exp=0", out_vld); end
  endtask

  task automatic test_partial();
    got.delete();
    shiftcnt = 5'd16;
    cs_low();
    send_bits(16'h1F, 5, 1'b1);
    cs_high();
    checks++; if (got.size() !== 0) begin failures++; $display("FAIL part_nobeat got=%0d exp=0", got.size()); end
    checks++; if (err_part !== 1'b1) begin failures++; $display("FAIL part_flag got=%b exp=1", err_part); end
    pulse_clr();
    checks++; if (err_part !== 1'b0) begin failures++; $display("FAIL part_clr got=%b exp=0", err_part); end
    cs_low();
    send_bits(16'h1234, 16, 1'b0);
    cs_high();
    wait_beats(1, "part_next");
    if (got.size() > 0) begin
      checks++; if (got[0] !== {1'b0, 16'h1234}) begin failures++; $display("FAIL part_next got=%h exp=%h", got[0], {1'b0, 16'h1234}); end
    end
  endtask

  task automatic test_len_clamp();
    got.delete();
    shiftcnt = 5'd20;
    cs_low();
    send_bits(16'hC0DE, 16, 1'b1);
    cs_high();
    wait_beats(1, "clamp");
    if (got.size() > 0) begin
      checks++; if (got[0] !== {1'b1, 16'hC0DE}) begin failures++; $display("FAIL clamp_word got=%h exp=%h", got[0], {1'b1, 16'hC0DE}); end
    end
    checks++; if (err_part !== 1'b0) begin failures++; $display("FAIL clamp_part got=%b exp=0", err_part); end
    got.delete();
    shiftcnt = 5'd0;
    cs_low();
    send_bits(16'hFFFF, 16, 1'b1);
    cs_high();
    checks++; if (got.size() !== 0) begin failures++; $display("FAIL zero_len got=%0d exp=0", got.size()); end
    checks++; if (err_part !== 1'b0) begin failures++; $display("FAIL zero_len_part got=%b exp=0", err_part); end
  endtask

  task automatic test_glitch();
    logic [15:0] word, expw;
    logic        expp;
    got.delete();
    pulse_clr();
    word = 16'hBEEF;
    shiftcnt = 5'd16;
    cs_low();
    send_bits(word >> 8, 8, 1'b1);
    lcd_mosi = 1'b0;
    lcd_sck = 1'b1;
    tick(1);
    lcd_sck = 1'b0;
    tick(4);
    send_bits(word & 16'hFF, 8, 1'b1);
    cs_high();
`ifdef RISCBOY_PPU_LCDRX_GLITCH_FILTER_EN
    expw = word;
    expp = 1'b0;
`else
    expw = ((word >> 8) << 8) | ((word & 16'hFF) >> 1);
    expp = 1'b1;
`endif
    wait_beats(1, "glitch");
    if (got.size() > 0) begin
      checks++; if (got[0][15:0] !== expw) begin failures++; $display("FAIL glitch_word got=%h exp=%h", got[0][15:0], expw); end
    end
    checks++; if (err_part !== expp) begin failures++; $display("FAIL glitch_part got=%b exp=%b", err_part, expp); end
    pulse_clr();
  endtask

  task automatic test_random();
    int l, lc, nw;
    logic [15:0] d;
    logic        dc;
    for (int w = 0; w < 8; w++) begin
      got.delete();
      exp_q.delete();
      l  = $urandom_range(1, 20);
      lc = (l > 16) ? 16 : l;
      nw = $urandom_range(1, 3);
      shiftcnt = 5'(l);
      cs_low();
      for (int k = 0; k < nw; k++) begin
        d  = 16'($urandom) & mask_of(lc);
        dc = 1'($urandom_range(0, 1));
        exp_q.push_back({dc, d});
        send_bits(d, lc, dc);
      end
      cs_high();
      wait_beats(exp_q.size(), "rand");
      for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
        checks++;
        if (got[k] !== exp_q[k]) begin
          failures++;
          $display("FAIL rand_word len=%0d idx=%0d got=%h exp=%h", l, k, got[k], exp_q[k]);
        end
      end
      checks++; if ({err_ovf, err_part} !== 2'b00) begin failures++; $display("FAIL rand_err len=%0d got=%b exp=00", l, {err_ovf, err_part}); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_partial();
    test_len_clamp();
    test_glitch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
